uart_config_loader: RTL

Command decoder that turns a byte stream from the UART receiver into write transactions on the UART configuration register's store port (`address`, `value`, `store_data`). It parses fixed-format configuration frames, validates each frame with an XOR checksum and an inter-byte timeout, and commits valid frames as single-cycle store pulses. It also produces an ACK/NAK response byte for the transmitter to echo back. It sits between the UART RX byte output and the configuration register, and is the only writer of that register.

---
 rtl/uart_config_loader_pkg.sv | 41 ++++
 rtl/uart_config_loader_if.sv | 31 +++
 rtl/uart_idle_timer.sv | 39 +++
 rtl/uart_config_loader.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/uart_config_loader_pkg.sv
// -----------------------------------------------------------------------------
// uart_config_loader_pkg
// Shared constants and types for the UART configuration command loader:
//   - command frame header pattern and ACK/NAK response codes
//   - loader FSM state encoding
//   - configuration register address map and value width
//   - is_header() helper used to recognise a frame header byte
// No ports (package).
// -----------------------------------------------------------------------------
package uart_config_loader_pkg;

    // Width of the widest configuration field (the delay-frames counter).
    localparam int UART_CONFIG_WIDTH_DELAYFRAMES = 16;

    // Configuration register address map.
    localparam logic [2:0] UART_CONFIG_ADDRESS_CLOCKDIV    = 3'd0;
    localparam logic [2:0] UART_CONFIG_ADDRESS_DELAYFRAMES = 3'd1;
    localparam logic [2:0] UART_CONFIG_ADDRESS_DATABITS    = 3'd2;
    localparam logic [2:0] UART_CONFIG_ADDRESS_STOPBITS    = 3'd3;
    localparam logic [2:0] UART_CONFIG_ADDRESS_PARITY      = 3'd4;
    localparam logic [2:0] UART_CONFIG_ADDRESS_FLOWCTRL    = 3'd5;
    localparam logic [2:0] UART_CONFIG_ADDRESS_MAX         = 3'd5;

    // Command frame header: upper five bits fixed, lower three carry the address.
    localparam logic [4:0] UART_CFGCMD_HDR = 5'b11000;
    localparam logic [7:0] UART_CFGCMD_ACK = 8'h06;
    localparam logic [7:0] UART_CFGCMD_NAK = 8'h15;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_VALUE  = 3'd1,
        ST_CHECK  = 3'd2,
        ST_COMMIT = 3'd3,
        ST_RESP   = 3'd4
    } loader_state_t;

    function automatic logic is_header(input logic [7:0] b);
        return b[7:3] == UART_CFGCMD_HDR;
    endfunction

endpackage

// File: rtl/uart_config_loader_if.sv
// -----------------------------------------------------------------------------
// uart_config_loader_if
// Bundles the loader's three handshakes:
//   rx_data/rx_valid/rx_ready       byte stream from the UART receiver
//   address/value/store_data        store port of the configuration register
//   resp_data/resp_valid/resp_ready ACK/NAK byte towards the transmitter
// master: the loader. slave: the surrounding RX/config/TX logic.
// -----------------------------------------------------------------------------
interface uart_config_loader_if #(
    parameter int COUNTER_WIDTH = uart_config_loader_pkg::UART_CONFIG_WIDTH_DELAYFRAMES
);
    logic [7:0]               rx_data;
    logic                     rx_valid;
    logic                     rx_ready;
    logic [2:0]               address;
    logic [COUNTER_WIDTH-1:0] value;
    logic                     store_data;
    logic                     resp_valid;
    logic [7:0]               resp_data;
    logic                     resp_ready;

    modport master (
        input  rx_data, rx_valid, resp_ready,
        output rx_ready, address, value, store_data, resp_valid, resp_data
    );

    modport slave (
        output rx_data, rx_valid, resp_ready,
        input  rx_ready, address, value, store_data, resp_valid, resp_data
    );
endinterface

// File: rtl/uart_idle_timer.sv
// -----------------------------------------------------------------------------
// uart_idle_timer
// Clear/enable idle counter with a terminal-count pulse. Counts clocks while
// enable is high; expired pulses on the TIMEOUT-th consecutive enabled cycle
// without a clear, and the counter restarts from zero.
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   clear       restart counting (has priority over expiry)
//   enable      count this cycle
//   expired     single-cycle terminal-count pulse
// -----------------------------------------------------------------------------
module uart_idle_timer #(
    parameter int TIMEOUT = 100000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);
    localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    logic [CNT_W-1:0] count;

    // Count value TIMEOUT-1 on an enabled cycle means this is the TIMEOUT-th idle clock.
    assign expired = enable & ~clear & (count == CNT_W'(TIMEOUT - 1));

    // NOTE: sequential state is written with non-blocking assignments only, so
    // every flop samples the pre-edge values regardless of process ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear || expired) begin
            count <= '0;
        end else if (enable) begin
            count <= count + 1'b1;
        end
    end
endmodule

// File: rtl/uart_config_loader.sv
// -----------------------------------------------------------------------------
// uart_config_loader
// Parses HDR, V0..V(N-1), CHK frames from the UART RX byte stream, checks the
// XOR checksum and an inter-byte idle timeout, and commits good frames to the
// configuration register as a single-cycle store pulse. Each complete frame is
// answered with ACK (stored) or NAK (bad checksum / unused address).
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   bus          uart_config_loader_if.master (RX stream, store port, response)
//   err_timeout  single-cycle pulse when a partial frame is dropped on timeout
// -----------------------------------------------------------------------------
module uart_config_loader
    import uart_config_loader_pkg::*;
#(
    parameter int COUNTER_WIDTH = UART_CONFIG_WIDTH_DELAYFRAMES,
    parameter int TIMEOUT       = 100000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    uart_config_loader_if.master  bus,
    output logic                  err_timeout
);
    localparam int NBYTES   = (COUNTER_WIDTH + 7) / 8;
    localparam int IDX_W    = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam int SHADOW_W = NBYTES * 8;

    loader_state_t state, state_next;

    logic                     ready_en;   // holds rx_ready low until the first clock after reset
    logic [2:0]               addr_q;
    logic [SHADOW_W-1:0]      shadow_q;
    logic [7:0]               chk_q;
    logic [IDX_W-1:0]         idx_q;
    logic [2:0]               address_q;
    logic [COUNTER_WIDTH-1:0] value_q;
    logic [7:0]               resp_q;

    logic rx_ready_int, accept, in_frame, timeout_hit;
    logic hdr_load, lane_load, commit_load, nak_load, ack_load, abort;
    logic store_int, resp_valid_int;

    assign rx_ready_int = ready_en &
                          ((state == ST_IDLE) || (state == ST_VALUE) || (state == ST_CHECK));
    assign accept       = bus.rx_valid & rx_ready_int;
    assign in_frame     = (state == ST_VALUE) || (state == ST_CHECK);

    assign bus.rx_ready   = rx_ready_int;
    assign bus.store_data = store_int;
    assign bus.resp_valid = resp_valid_int;
    assign bus.resp_data  = resp_q;
    assign bus.address    = address_q;
    assign bus.value      = value_q;

    // Outside a frame the timer is held clear so every frame starts from zero.
    uart_idle_timer #(.TIMEOUT(TIMEOUT)) u_idle_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (accept | ~in_frame),
        .enable  (in_frame),
        .expired (timeout_hit)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_next;
    end

    // NOTE: every output of this block gets a default before the case, so no
    // path leaves a signal unassigned and no latch is inferred.
    always_comb begin
        state_next     = state;
        store_int      = 1'b0;
        resp_valid_int = 1'b0;
        err_timeout    = 1'b0;
        hdr_load       = 1'b0;
        lane_load      = 1'b0;
        commit_load    = 1'b0;
        nak_load       = 1'b0;
        ack_load       = 1'b0;
        abort          = 1'b0;

        unique case (state)
            ST_IDLE: begin
                // Non-header bytes are silently dropped while hunting for a frame.
                if (accept && is_header(bus.rx_data)) begin
                    hdr_load   = 1'b1;
                    state_next = ST_VALUE;
                end
            end
            ST_VALUE: begin
                if (accept) begin
                    lane_load = 1'b1;
                    if (idx_q == IDX_W'(NBYTES - 1)) state_next = ST_CHECK;
                end else if (timeout_hit) begin
                    err_timeout = 1'b1;
                    abort       = 1'b1;
                    state_next  = ST_IDLE;
                end
            end
            ST_CHECK: begin
                if (accept) begin
                    if (bus.rx_data == chk_q && addr_q <= UART_CONFIG_ADDRESS_MAX) begin
                        commit_load = 1'b1;
                        state_next  = ST_COMMIT;
                    end else begin
                        nak_load   = 1'b1;
                        state_next = ST_RESP;
                    end
                end else if (timeout_hit) begin
                    err_timeout = 1'b1;
                    abort       = 1'b1;
                    state_next  = ST_IDLE;
                end
            end
            ST_COMMIT: begin
                store_int  = 1'b1;
                ack_load   = 1'b1;
                state_next = ST_RESP;
            end
            ST_RESP: begin
                resp_valid_int = 1'b1;
                if (bus.resp_ready) state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Datapath. address/value are loaded on the checksum-accept edge so they
    // already carry the shadow contents during COMMIT and hold them afterwards.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ready_en  <= 1'b0;
            addr_q    <= '0;
            shadow_q  <= '0;
            chk_q     <= '0;
            idx_q     <= '0;
            address_q <= '0;
            value_q   <= '0;
            resp_q    <= UART_CFGCMD_NAK;
        end else begin
            ready_en <= 1'b1;
            if (hdr_load) begin
                addr_q <= bus.rx_data[2:0];
                chk_q  <= bus.rx_data;
                idx_q  <= '0;
            end
            if (lane_load) begin
                for (int i = 0; i < NBYTES; i++) begin
                    if (idx_q == IDX_W'(i)) shadow_q[i*8 +: 8] <= bus.rx_data;
                end
                chk_q <= chk_q ^ bus.rx_data;
                idx_q <= idx_q + 1'b1;
            end
            if (commit_load) begin
                address_q <= addr_q;
                // Bits of the last lane above COUNTER_WIDTH are checksummed but dropped here.
                value_q   <= shadow_q[COUNTER_WIDTH-1:0];
            end
            if (nak_load) resp_q <= UART_CFGCMD_NAK;
            if (ack_load) resp_q <= UART_CFGCMD_ACK;
            if (abort) begin
                shadow_q <= '0;
                chk_q    <= '0;
                idx_q    <= '0;
            end
        end
    end
endmodule
